// File: rtl/hack_cpu_core.sv
// Hack CPU execution core: decodes the held instruction, drives the ALU and commits A/D/PC/memory writes.
// Latency: two cycles per instruction (FETCH handshake + EXEC), plus one cycle per FETCH stall.
// Backpressure: inst_ready is high only in FETCH; inst is ignored throughout EXEC.
module hack_cpu_core #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   inst,
    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic [WIDTH-1:0]   inM,
    output logic [WIDTH-1:0]   outM,
    output logic               writeM,
    output logic [WIDTH-2:0]   addressM,
    output logic [WIDTH-2:0]   pc
);

    localparam int AW = WIDTH - 1;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] ir;
    logic [AW-1:0]    pc_reg;

    logic             is_c;
    logic             sel_m;
    logic             zx, nx, zy, ny, f, no;
    logic             dest_a, dest_d, dest_m;
    logic             j_lt, j_eq, j_gt;
    logic             unused_ir_bits;

    logic [WIDTH-1:0] alu_x, alu_y;
    logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_res;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zr, alu_ng;
    logic             jump;
    logic [AW-1:0]    pc_inc;

    assign is_c   = ir[15];
    assign sel_m  = ir[12];
    assign zx     = ir[11];
    assign nx     = ir[10];
    assign zy     = ir[9];
    assign ny     = ir[8];
    assign f      = ir[7];
    assign no     = ir[6];
    assign dest_a = ir[5];
    assign dest_d = ir[4];
    assign dest_m = ir[3];
    assign j_lt   = ir[2];
    assign j_eq   = ir[1];
    assign j_gt   = ir[0];

    // The two bits between the opcode and the a-bit carry no meaning in the ISA.
    assign unused_ir_bits = ^ir[14:13];

    assign alu_x = d_reg;
    assign alu_y = sel_m ? inM : a_reg;

    always_comb begin
        x_z     = zx ? '0 : alu_x;
        x_n     = nx ? ~x_z : x_z;
        y_z     = zy ? '0 : alu_y;
        y_n     = ny ? ~y_z : y_z;
        f_res   = f ? (x_n + y_n) : (x_n & y_n);
        alu_out = no ? ~f_res : f_res;
    end

    assign alu_zr = (alu_out == '0);
    assign alu_ng = alu_out[WIDTH-1];
    assign jump   = (j_lt & alu_ng) | (j_eq & alu_zr) | (j_gt & ~alu_ng & ~alu_zr);
    assign pc_inc = pc_reg + AW'(1);

    // writeM comes straight off the state register so reset kills it without waiting for an edge.
    assign inst_ready = (state == FETCH);
    assign writeM     = (state == EXEC) & is_c & dest_m;
    assign outM       = alu_out;
    assign addressM   = a_reg[AW-1:0];
    assign pc         = pc_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FETCH;
            a_reg  <= '0;
            d_reg  <= '0;
            ir     <= '0;
            pc_reg <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (inst_valid) begin
                        ir    <= inst;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!is_c) begin
                        a_reg  <= ir;
                        pc_reg <= pc_inc;
                    end else begin
                        // Jump target and store address both use A as it was before this commit.
                        if (dest_a) a_reg <= alu_out;
                        if (dest_d) d_reg <= alu_out;
                        pc_reg <= jump ? a_reg[AW-1:0] : pc_inc;
                    end
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_core.sv
// Bench for hack_cpu_core: instruction-level model feeds an expectation queue, EXEC observations are compared in order.
`timescale 1ns/1ps
module tb_hack_cpu_core;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] inst = 16'h0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [15:0] inM = 16'h0;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    hack_cpu_core #(.WIDTH(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inM        (inM),
        .outM       (outM),
        .writeM     (writeM),
        .addressM   (addressM),
        .pc         (pc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] outm;
        logic        wm;
        logic [14:0] addr;
        logic        rdy;
        logic [14:0] pc_exec;
        logic [14:0] pc_next;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   wm_cnt = 0;
    logic [15:0] ma, md;
    logic [14:0] mpc;

    always @(negedge clock) if (reset_n && writeM) wm_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, wanted completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Hack comp table (c1..c6), y is A or M depending on the a-bit.
    function automatic logic [15:0] comp(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'h0000;
            6'b111111: return 16'h0001;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'h0 - x;
            6'b110011: return 16'h0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic model_push(input logic [15:0] i, input logic [15:0] m);
        rec_t e;
        logic [15:0] r;
        logic j;
        e.rdy = 1'b0;
        e.pc_exec = mpc;
        e.addr = ma[14:0];
        if (!i[15]) begin
            e.outm = 16'h0;
            e.wm = 1'b0;
            e.pc_next = mpc + 15'd1;
            ma = i;
        end else begin
            r = comp(i[11:6], md, i[12] ? m : ma);
            e.outm = r;
            e.wm = i[3];
            j = (i[2] && $signed(r) < 0) || (i[1] && r == 16'h0) || (i[0] && $signed(r) > 0);
            e.pc_next = j ? ma[14:0] : mpc + 15'd1;
            if (i[5]) ma = r;
            if (i[4]) md = r;
        end
        mpc = e.pc_next;
        exp_q.push_back(e);
    endtask

    // Called at a negedge in FETCH; returns at the negedge of the following FETCH cycle.
    task automatic send(input logic [15:0] i, input logic [15:0] m, input int stall);
        rec_t o;
        int n;
        model_push(i, m);
        repeat (stall) @(negedge clock);
        inst = i;
        inst_valid = 1'b1;
        inM = m;
        n = 0;
        while (inst_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: inst_ready=%b after 20 cycles, wanted 1", inst_ready);
        end
        @(posedge clock);
        @(negedge clock);
        inst = 16'($urandom);
        inst_valid = 1'b1;
        o.outm = i[15] ? outM : 16'h0;
        o.wm = writeM;
        o.addr = addressM;
        o.rdy = inst_ready;
        o.pc_exec = pc;
        @(negedge clock);
        inst_valid = 1'b0;
        o.pc_next = pc;
        obs_q.push_back(o);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        inst_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ma = 16'h0; md = 16'h0; mpc = 15'h0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        ma = 16'h0; md = 16'h0; mpc = 15'h0;
        reset_n = 1'b0;
        inst = 16'hFFFF;
        inst_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            n_checks++;
            if ({inst_ready, writeM, pc, addressM, outM} !== {1'b1, 1'b0, 15'h0, 15'h0, 16'h0}) begin
                n_fail++;
                $display("FAIL reset_outputs: rdy=%b wm=%b pc=%h addr=%h out=%h, wanted 1 0 0000 0000 0000",
                         inst_ready, writeM, pc, addressM, outM);
            end
        end
        reset_n = 1'b1;
        inst_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if ({inst_ready, writeM, pc} !== {1'b1, 1'b0, 15'h0}) begin
                n_fail++;
                $display("FAIL idle[%0d]: rdy=%b wm=%b pc=%h, wanted 1 0 0000", k, inst_ready, writeM, pc);
            end
        end
    endtask

    task automatic test_add_store();
        rec_t e, o;
        int w0, k;
        w0 = wm_cnt;
        send(16'h0002, 16'h0, 0);
        send(16'hEC10, 16'h0, 0);
        send(16'h0003, 16'h0, 0);
        send(16'hE090, 16'h0, 0);
        send(16'h0000, 16'h0, 0);
        send(16'hE308, 16'h0, 0);
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL add_store[%0d]: got out=%h wm=%b addr=%h rdy=%b pc=%h->%h want out=%h wm=%b addr=%h rdy=%b pc=%h->%h",
                         k, o.outm, o.wm, o.addr, o.rdy, o.pc_exec, o.pc_next, e.outm, e.wm, e.addr, e.rdy, e.pc_exec, e.pc_next);
            end
            k++;
        end
        n_checks++;
        if ({wm_cnt - w0, pc} !== {32'd1, 15'd6}) begin
            n_fail++;
            $display("FAIL add_store_summary: write pulses=%0d pc=%h, wanted 1 and 0006", wm_cnt - w0, pc);
        end
    endtask

    task automatic test_mem_operand();
        rec_t e, o;
        int w0, k;
        w0 = wm_cnt;
        send(16'h0007, 16'h0, 0);
        send(16'hFC10, 16'h1234, 0);
        send(16'hE300, 16'h0, 1);
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mem_operand[%0d]: got out=%h wm=%b addr=%h rdy=%b pc=%h->%h want out=%h wm=%b addr=%h rdy=%b pc=%h->%h",
                         k, o.outm, o.wm, o.addr, o.rdy, o.pc_exec, o.pc_next, e.outm, e.wm, e.addr, e.rdy, e.pc_exec, e.pc_next);
            end
            k++;
        end
        n_checks++;
        if (wm_cnt != w0) begin
            n_fail++;
            $display("FAIL mem_operand_nowrite: write pulses=%0d, wanted 0", wm_cnt - w0);
        end
    endtask

    task automatic test_jumps();
        rec_t e, o;
        int k;
        send(16'h000A, 16'h0, 0);
        send(16'hEA87, 16'h0, 0);
        n_checks++;
        if (pc !== 15'd10) begin
            n_fail++;
            $display("FAIL jmp_uncond: pc=%h, wanted 000a", pc);
        end
        send(16'h0005, 16'h0, 0);
        send(16'hEC10, 16'h0, 0);
        send(16'h0014, 16'h0, 0);
        send(16'hE301, 16'h0, 0);
        n_checks++;
        if (pc !== 15'd20) begin
            n_fail++;
            $display("FAIL jgt_taken: pc=%h, wanted 0014", pc);
        end
        send(16'h0000, 16'h0, 0);
        send(16'hEC10, 16'h0, 0);
        send(16'h0014, 16'h0, 0);
        send(16'hE301, 16'h0, 0);
        n_checks++;
        if (pc !== 15'd24) begin
            n_fail++;
            $display("FAIL jgt_not_taken: pc=%h, wanted 0018", pc);
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL jumps[%0d]: got out=%h wm=%b addr=%h rdy=%b pc=%h->%h want out=%h wm=%b addr=%h rdy=%b pc=%h->%h",
                         k, o.outm, o.wm, o.addr, o.rdy, o.pc_exec, o.pc_next, e.outm, e.wm, e.addr, e.rdy, e.pc_exec, e.pc_next);
            end
            k++;
        end
    endtask

    task automatic test_wrap();
        rec_t e, o;
        int k;
        send(16'h0000, 16'h0, 0);
        send(16'hECA0, 16'h0, 0);
        send(16'hEC00, 16'h0, 0);
        n_checks++;
        if ({outM, addressM} !== {16'hFFFF, 15'h7FFF}) begin
            n_fail++;
            $display("FAIL a_wrap: A via outM=%h addr=%h, wanted ffff 7fff", outM, addressM);
        end
        send(16'h7FFF, 16'h0, 0);
        send(16'hEA87, 16'h0, 0);
        n_checks++;
        if (pc !== 15'h7FFF) begin
            n_fail++;
            $display("FAIL pc_to_top: pc=%h, wanted 7fff", pc);
        end
        send(16'h0000, 16'h0, 0);
        n_checks++;
        if (pc !== 15'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h, wanted 0000", pc);
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got out=%h wm=%b addr=%h rdy=%b pc=%h->%h want out=%h wm=%b addr=%h rdy=%b pc=%h->%h",
                         k, o.outm, o.wm, o.addr, o.rdy, o.pc_exec, o.pc_next, e.outm, e.wm, e.addr, e.rdy, e.pc_exec, e.pc_next);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        int k, w0;
        time t0, t1;
        w0 = wm_cnt;
        t0 = $time;
        send(16'h0001, 16'h0, 0);
        send(16'hEC10, 16'h0, 0);
        send(16'hE7D0, 16'h0, 0);
        send(16'hE308, 16'h0, 0);
        t1 = $time;
        n_checks++;
        if (t1 - t0 != 80) begin
            n_fail++;
            $display("FAIL b2b_rate: 4 instructions took %0t, wanted 80", t1 - t0);
        end
        send(16'hE308, 16'h0, 3);
        n_checks++;
        if ($time - t1 != 50) begin
            n_fail++;
            $display("FAIL stall_rate: stalled instruction took %0t, wanted 50", $time - t1);
        end
        n_checks++;
        if (wm_cnt - w0 != 2) begin
            n_fail++;
            $display("FAIL b2b_writes: write pulses=%0d, wanted 2", wm_cnt - w0);
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got out=%h wm=%b addr=%h rdy=%b pc=%h->%h want out=%h wm=%b addr=%h rdy=%b pc=%h->%h",
                         k, o.outm, o.wm, o.addr, o.rdy, o.pc_exec, o.pc_next, e.outm, e.wm, e.addr, e.rdy, e.pc_exec, e.pc_next);
            end
            k++;
        end
    endtask

    task automatic test_reset_exec();
        rec_t e, o;
        int k;
        do_reset();
        send(16'h0000, 16'h0, 0);
        inst = 16'hE308;
        inst_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inst_valid = 1'b0;
        n_checks++;
        if ({writeM, inst_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL exec_before_reset: wm=%b rdy=%b, wanted 1 0", writeM, inst_ready);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({writeM, inst_ready, pc} !== {1'b0, 1'b1, 15'h0}) begin
            n_fail++;
            $display("FAIL reset_in_exec: wm=%b rdy=%b pc=%h, wanted 0 1 0000", writeM, inst_ready, pc);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ma = 16'h0; md = 16'h0; mpc = 15'h0;
        exp_q.delete();
        obs_q.delete();
        @(negedge clock);
        n_checks++;
        if ({inst_ready, writeM, pc} !== {1'b1, 1'b0, 15'h0}) begin
            n_fail++;
            $display("FAIL release_state: rdy=%b wm=%b pc=%h, wanted 1 0 0000", inst_ready, writeM, pc);
        end
        send(16'hE300, 16'h0, 0);
        send(16'hEC00, 16'h0, 0);
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_exec[%0d]: got out=%h wm=%b addr=%h rdy=%b pc=%h->%h want out=%h wm=%b addr=%h rdy=%b pc=%h->%h",
                         k, o.outm, o.wm, o.addr, o.rdy, o.pc_exec, o.pc_next, e.outm, e.wm, e.addr, e.rdy, e.pc_exec, e.pc_next);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_add_store();
        test_mem_operand();
        test_jumps();
        test_wrap();
        test_back_to_back();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
